trc_step_sequencer: RTL

- Programmable stimulus sequencer for the TRC event state machine.
- Drives the FSM's ctrl/mng inputs from a small step table, holding each step for a programmed number of clock cycles.
- Samples the FSM's 4-bit event code at the end of every step and reports it as a logged record.
- Sits between the configuration interface and the event FSM; one sequencer per FSM instance.

---
 rtl/trc_step_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/trc_step_sequencer.sv
// Step-table driven stimulus sequencer for the TRC event FSM.
// Holds each programmed ctrl/mng step for its dwell count and logs the FSM event code at each step end.
module trc_step_sequencer #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic               cfg_ctrl,
    input  logic               cfg_mng,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_last,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [3:0]         evnt_in,
    output logic               ctrl,
    output logic               mng,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  step_idx,
    output logic [3:0]         evnt_log,
    output logic [ADDR_W-1:0]  log_idx,
    output logic               log_valid,
    output logic [7:0]         loop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    // A zero dwell still occupies one cycle.
    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
        return (d == {DWELL_W{1'b0}}) ? CNT_ONE : d;
    endfunction

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 ctrl_q, ctrl_d, mng_q, mng_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]    step_idx_q, step_idx_d, log_idx_q, log_idx_d;
    logic [3:0]           evnt_log_q, evnt_log_d;
    logic                 log_valid_q, log_valid_d;
    logic [7:0]           loop_cnt_q, loop_cnt_d;

    logic                 tbl_ctrl_q  [DEPTH];
    logic                 tbl_ctrl_d  [DEPTH];
    logic                 tbl_mng_q   [DEPTH];
    logic                 tbl_mng_d   [DEPTH];
    logic [DWELL_W-1:0]   tbl_dwell_q [DEPTH];
    logic [DWELL_W-1:0]   tbl_dwell_d [DEPTH];
    logic                 tbl_last_q  [DEPTH];
    logic                 tbl_last_d  [DEPTH];

    logic                 addr_ok_s;
    logic [ADDR_W-1:0]    nxt_idx_s;
    logic                 end_of_prog_s;

    assign addr_ok_s     = ({1'b0, cfg_addr} < DEPTH_C);
    assign nxt_idx_s     = step_idx_q + IDX_ONE;
    assign end_of_prog_s = tbl_last_q[step_idx_q] || (step_idx_q == LAST_IDX);

    // Next-state, table-write and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        mng_d       = mng_q;
        busy_d      = busy_q;
        done_d      = done_q;
        step_idx_d  = step_idx_q;
        log_idx_d   = log_idx_q;
        evnt_log_d  = evnt_log_q;
        log_valid_d = 1'b0;
        loop_cnt_d  = loop_cnt_q;
        tbl_ctrl_d  = tbl_ctrl_q;
        tbl_mng_d   = tbl_mng_q;
        tbl_dwell_d = tbl_dwell_q;
        tbl_last_d  = tbl_last_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_we && addr_ok_s) begin
                    tbl_ctrl_d[cfg_addr]  = cfg_ctrl;
                    tbl_mng_d[cfg_addr]   = cfg_mng;
                    tbl_dwell_d[cfg_addr] = cfg_dwell;
                    tbl_last_d[cfg_addr]  = cfg_last;
                end else begin
                    tbl_last_d = tbl_last_q;
                end
                // stop wins over a simultaneous start outside RUN.
                if (start && !stop) begin
                    state_d    = S_RUN;
                    step_idx_d = {ADDR_W{1'b0}};
                    ctrl_d     = tbl_ctrl_q[0];
                    mng_d      = tbl_mng_q[0];
                    cnt_d      = eff_dwell(tbl_dwell_q[0]);
                    loop_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d    = S_IDLE;
                    ctrl_d     = 1'b0;
                    mng_d      = 1'b0;
                    step_idx_d = {ADDR_W{1'b0}};
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                end else if (cnt_q == CNT_ONE) begin
                    log_valid_d = 1'b1;
                    log_idx_d   = step_idx_q;
                    evnt_log_d  = evnt_in;
                    if (end_of_prog_s && loop_en) begin
                        step_idx_d = {ADDR_W{1'b0}};
                        ctrl_d     = tbl_ctrl_q[0];
                        mng_d      = tbl_mng_q[0];
                        cnt_d      = eff_dwell(tbl_dwell_q[0]);
                        loop_cnt_d = (loop_cnt_q == 8'hFF) ? 8'hFF : loop_cnt_q + 8'd1;
                    end else if (end_of_prog_s) begin
                        state_d = S_DONE;
                        ctrl_d  = 1'b0;
                        mng_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        step_idx_d = nxt_idx_s;
                        ctrl_d     = tbl_ctrl_q[nxt_idx_s];
                        mng_d      = tbl_mng_q[nxt_idx_s];
                        cnt_d      = eff_dwell(tbl_dwell_q[nxt_idx_s]);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                ctrl_d     = 1'b0;
                mng_d      = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                step_idx_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, output and step-table registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {DWELL_W{1'b0}};
            ctrl_q      <= 1'b0;
            mng_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_idx_q  <= {ADDR_W{1'b0}};
            log_idx_q   <= {ADDR_W{1'b0}};
            evnt_log_q  <= 4'd0;
            log_valid_q <= 1'b0;
            loop_cnt_q  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_ctrl_q[i]  <= 1'b0;
                tbl_mng_q[i]   <= 1'b0;
                tbl_dwell_q[i] <= {DWELL_W{1'b0}};
                tbl_last_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            mng_q       <= mng_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_idx_q  <= step_idx_d;
            log_idx_q   <= log_idx_d;
            evnt_log_q  <= evnt_log_d;
            log_valid_q <= log_valid_d;
            loop_cnt_q  <= loop_cnt_d;
            tbl_ctrl_q  <= tbl_ctrl_d;
            tbl_mng_q   <= tbl_mng_d;
            tbl_dwell_q <= tbl_dwell_d;
            tbl_last_q  <= tbl_last_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign mng       = mng_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_idx  = step_idx_q;
    assign evnt_log  = evnt_log_q;
    assign log_idx   = log_idx_q;
    assign log_valid = log_valid_q;
    assign loop_cnt  = loop_cnt_q;

endmodule
